rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources:
  - port A, the in-order pipeline writeback;
  - port B, a multi-cycle unit, e.g. a divider or load miss return.
- Each source uses a valid/ready handshake; the block issues one write per cycle.
- It registers the winning write into a one-stage output buffer that drives the register file's `reg_write`/`rd`/`writedata` pins.
- It exports a pending-write mask that hazard logic uses to stall readers of registers with writes still in flight.

---
 rtl/rf_write_arbiter_if.sv | 54 +++++
 rtl/rf_write_arbiter.sv | 102 ++++++++++
 tb/tb_rf_write_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundles the two writeback request ports (A: in-order pipeline, B:
//   multi-cycle unit), the register-file write pins and the hazard/priority
//   status outputs of rf_write_arbiter.
//
//   Signals:
//     a_valid/a_rd/a_data, a_ready   port A request and acceptance
//     b_valid/b_rd/b_data, b_ready   port B request and acceptance
//     rf_reg_write/rf_rd/rf_writedata register file write port
//     pending_mask                   registers with writes in flight
//     last_grant                     0 = A won last arbitration, 1 = B
//
//   Modports:
//     master - requester / consumer side (pipeline, register file, hazard unit)
//     slave  - the arbiter itself
`timescale 1ns/1ps

interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_writedata;

  logic [31:0]       pending_mask;
  logic              last_grant;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready,
    input  rf_reg_write, rf_rd, rf_writedata,
    input  pending_mask, last_grant
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready,
    output rf_reg_write, rf_rd, rf_writedata,
    output pending_mask, last_grant
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the in-order
//   pipeline writeback (port A) and a multi-cycle unit (port B). One request
//   is accepted per cycle and registered into a one-stage output buffer that
//   drives the register file pins. A combinational pending mask flags every
//   register with a write waiting on a port or sitting in the output stage.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    rf_write_arbiter_if.slave (request ports, RF pins, status)
//
//   Build option:
//     RF_ARB_FIXED_PRIO_EN - when defined, port A always wins conflicts;
//                            last_grant is still tracked and output.
//                            Undefined (default): round-robin on last_grant.
`timescale 1ns/1ps

module rf_write_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e             last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic grant_a;
  logic grant_b;

  // Grant depends only on valids and the priority pointer, never on ready.
  always_comb begin
`ifdef RF_ARB_FIXED_PRIO_EN
    grant_a = bus.a_valid;
`else
    grant_a = bus.a_valid && (!bus.b_valid || (last_grant_q == PORT_B));
`endif
    grant_b = bus.b_valid && !grant_a;
  end

  // Nothing transfers while reset is held, so requests stay on their ports.
  assign bus.a_ready = grant_a && !reset;
  assign bus.b_ready = grant_b && !reset;

  always_comb begin
    we_d         = 1'b0;
    rd_d         = rd_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    if (grant_a) begin
      rd_d         = bus.a_rd;
      data_d       = bus.a_data;
      we_d         = (bus.a_rd != '0);
      last_grant_d = PORT_A;
    end else if (grant_b) begin
      rd_d         = bus.b_rd;
      data_d       = bus.b_data;
      we_d         = (bus.b_rd != '0);
      last_grant_d = PORT_B;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q         <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      last_grant_q <= PORT_B;
    end else begin
      we_q         <= we_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rf_reg_write = we_q;
  assign bus.rf_rd        = rd_q;
  assign bus.rf_writedata = data_q;
  assign bus.last_grant   = last_grant_q;

  // Bit 0 stays clear: writes to x0 are accepted but never performed.
  always_comb begin
    bus.pending_mask = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      bus.pending_mask[i] = (bus.a_valid && (bus.a_rd == ADDR_W'(i))) ||
                            (bus.b_valid && (bus.b_rd == ADDR_W'(i))) ||
                            (we_q        && (rd_q     == ADDR_W'(i)));
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Self-checking bench for rf_write_arbiter: a table of directed per-cycle
//   vectors, a hand-written mid-cycle reset sequence, then randomized traffic
//   compared against a behavioural model of the arbitration rules.
//   Define RF_ARB_FIXED_PRIO_EN for both bench and RTL to check fixed priority.
`timescale 1ns/1ps

module tb_rf_write_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
`ifdef RF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic reset;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] adat;
    logic        bv;
    logic [4:0]  brd;
    logic [63:0] bdat;
    logic        ear;
    logic        ebr;
    logic        ewe;
    logic [4:0]  erd;
    logic [63:0] edat;
    logic [31:0] emask;
    logic        elg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic av, input logic [4:0] ard,
                     input logic [63:0] adat, input logic bv, input logic [4:0] brd,
                     input logic [63:0] bdat, input logic ear, input logic ebr,
                     input logic ewe, input logic [4:0] erd, input logic [63:0] edat,
                     input logic [31:0] emask, input logic elg);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.bv = bv; v.brd = brd; v.bdat = bdat;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.erd = erd; v.edat = edat;
    v.emask = emask; v.elg = elg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ear, input logic ebr,
                           input logic ewe, input logic [4:0] erd, input logic [63:0] edat,
                           input logic [31:0] emask, input logic elg);
    chk({tag, "/a_ready"},      64'(bus.a_ready),      64'(ear));
    chk({tag, "/b_ready"},      64'(bus.b_ready),      64'(ebr));
    chk({tag, "/rf_reg_write"}, 64'(bus.rf_reg_write), 64'(ewe));
    chk({tag, "/rf_rd"},        64'(bus.rf_rd),        64'(erd));
    chk({tag, "/rf_writedata"}, bus.rf_writedata,      edat);
    chk({tag, "/pending_mask"}, 64'(bus.pending_mask), 64'(emask));
    chk({tag, "/last_grant"},   64'(bus.last_grant),   64'(elg));
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                       input logic [63:0] adat, input logic bv, input logic [4:0] brd,
                       input logic [63:0] bdat);
    reset       = rst;
    bus.a_valid = av;
    bus.a_rd    = ard;
    bus.a_data  = adat;
    bus.b_valid = bv;
    bus.b_rd    = brd;
    bus.b_data  = bdat;
  endtask

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Behavioural model state for the random phase.
  logic        m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic        m_lg;
  logic        pav, pbv;
  logic [4:0]  pard, pbrd;
  logic [63:0] padat, pbdat;

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

    // Expected values: ready/mask for the inputs applied this cycle,
    // rf_*/last_grant as registered at the previous rising edge.
    //  rst av ard adat      bv brd bdat     ear ebr ewe erd edat       emask      elg
    add(1, 0, 0, 0,        0, 0,  0,       0, 0, 0, 0,  0,         32'h0,    1);
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 0, 0,  0,         32'h0,    1);
    add(0, 1, 3, 64'h55,   0, 0,  0,       1, 0, 0, 0,  0,         32'h8,    1);
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 1, 3,  64'h55,    32'h8,    0);
    add(1, 0, 0, 0,        0, 0,  0,       0, 0, 0, 0,  0,         32'h0,    1);
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  1, 0, 0, 0,  0,         32'h60,   1);
`ifndef RF_ARB_FIXED_PRIO_EN
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  0, 1, 1, 5,  64'hA5,    32'h60,   0);
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  1, 0, 1, 6,  64'hB6,    32'h60,   1);
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  0, 1, 1, 5,  64'hA5,    32'h60,   0);
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 1, 6,  64'hB6,    32'h40,   1);
    add(0, 1, 0, 64'hFFFF, 0, 0,  0,       1, 0, 0, 6,  64'hB6,    32'h0,    1);
`else
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  1, 0, 1, 5,  64'hA5,    32'h60,   0);
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  1, 0, 1, 5,  64'hA5,    32'h60,   0);
    add(0, 1, 5, 64'hA5,   1, 6,  64'hB6,  1, 0, 1, 5,  64'hA5,    32'h60,   0);
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 1, 5,  64'hA5,    32'h20,   0);
    add(0, 1, 0, 64'hFFFF, 0, 0,  0,       1, 0, 0, 5,  64'hA5,    32'h0,    0);
`endif
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 0, 0,  64'hFFFF,  32'h0,    0);
    add(1, 0, 0, 0,        0, 0,  0,       0, 0, 0, 0,  0,         32'h0,    1);
    add(0, 1, 9, 64'h1,    1, 9,  64'h2,   1, 0, 0, 0,  0,         32'h200,  1);
    add(0, 0, 0, 0,        1, 9,  64'h2,   0, 1, 1, 9,  64'h1,     32'h200,  0);
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 1, 9,  64'h2,     32'h200,  1);
    add(0, 1, 7, 64'h77,   1, 12, 64'hC,   1, 0, 0, 9,  64'h2,     32'h1080, 1);
    add(1, 0, 0, 0,        1, 12, 64'hC,   0, 0, 0, 0,  0,         32'h1000, 1);
    add(0, 0, 0, 0,        1, 12, 64'hC,   0, 1, 0, 0,  0,         32'h1000, 1);
    add(0, 0, 0, 0,        0, 0,  0,       0, 0, 1, 12, 64'hC,     32'h1000, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat,
            vecs[i].bv, vecs[i].brd, vecs[i].bdat);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ear, vecs[i].ebr, vecs[i].ewe,
                vecs[i].erd, vecs[i].edat, vecs[i].emask, vecs[i].elg);
    end

    // Reset asserted in the middle of a cycle with a live write in the
    // output stage and an unaccepted B request waiting.
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd4, 64'h44, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("mid/we_before",   64'(bus.rf_reg_write), 64'd1);
    chk("mid/rd_before",   64'(bus.rf_rd),        64'd4);
    chk("mid/data_before", bus.rf_writedata,      64'h44);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd13, 64'hDD);
    #2;
    reset = 1'b1;
    #1;
    check_all("mid/in_reset", 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 32'h2000, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid/b_ready_after", 64'(bus.b_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("mid/we_after",   64'(bus.rf_reg_write), 64'd1);
    chk("mid/rd_after",   64'(bus.rf_rd),        64'd13);
    chk("mid/data_after", bus.rf_writedata,      64'hDD);
    chk("mid/lg_after",   64'(bus.last_grant),   64'd1);
    bus.b_valid = 1'b0;

    // Randomized traffic: each port holds its request until accepted.
    pav = 1'b0; pbv = 1'b0;
    pard = '0; pbrd = '0; padat = '0; pbdat = '0;
    m_we = 1'b0; m_rd = '0; m_data = '0; m_lg = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        ga, gb;
      logic [31:0] emask;
      @(negedge clk);
      r = (n == 0) || ($urandom_range(0, 63) == 0);
      if (!pav && $urandom_range(0, 99) < 60) begin
        pav = 1'b1; pard = pick_rd(); padat = {$urandom, $urandom};
      end
      if (!pbv && $urandom_range(0, 99) < 60) begin
        pbv = 1'b1; pbrd = pick_rd(); pbdat = {$urandom, $urandom};
      end
      drive(r, pav, pard, padat, pbv, pbrd, pbdat);

      if (r) begin
        m_we = 1'b0; m_rd = '0; m_data = '0; m_lg = 1'b1;
      end
      ga = 1'b0;
      gb = 1'b0;
      if (!r) begin
        if (pav && pbv) ga = FIXED ? 1'b1 : (m_lg == 1'b1);
        else            ga = pav;
        gb = pbv && !ga;
      end
      emask = '0;
      for (int i = 1; i < 32; i++) begin
        if ((pav && pard == 5'(i)) || (pbv && pbrd == 5'(i)) || (m_we && m_rd == 5'(i)))
          emask[i] = 1'b1;
      end
      #1;
      check_all($sformatf("rnd%0d", n), ga, gb, m_we, m_rd, m_data, emask, m_lg);

      if (ga) begin
        m_we = (pard != 0); m_rd = pard; m_data = padat; m_lg = 1'b0; pav = 1'b0;
      end else if (gb) begin
        m_we = (pbrd != 0); m_rd = pbrd; m_data = pbdat; m_lg = 1'b1; pbv = 1'b0;
      end else begin
        m_we = 1'b0;
      end
    end

    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
